// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue
//
// Writeback-side driver for the register file write port. Two producers
// (ALU and memory) hand over register writes through valid/ready
// handshakes. Accepted writes queue in a small in-order FIFO that drains
// at one register-file write per cycle. Combinational forwarding lookups
// let both read ports see writes that are still waiting in the queue.
// Writes to the zero register (all-ones address, XZR) are accepted and
// dropped.
//
// Ports:
//   clk                  rising-edge clock
//   reset                asynchronous, active-low reset
//   alu_valid/ready      ALU request handshake (alu_addr, alu_data)
//   mem_valid/ready      memory request handshake (mem_addr, mem_data);
//                        memory has fixed priority over the ALU
//   hold                 1 = do not drain the FIFO this cycle
//   write/wrAddr/wrData  register-file write port (head of the FIFO)
//   rdAddrA/rdAddrB      read addresses for the forwarding lookup
//   fwdHitA/fwdDataA     youngest pending write matching rdAddrA
//   fwdHitB/fwdDataB     youngest pending write matching rdAddrB
//   count                number of occupied FIFO entries
module regfile_writeback_queue #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [ADDR_W-1:0]          alu_addr,
  input  logic [DATA_W-1:0]          alu_data,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [ADDR_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]          mem_data,
  input  logic                       hold,
  output logic                       write,
  output logic [ADDR_W-1:0]          wrAddr,
  output logic [DATA_W-1:0]          wrData,
  input  logic [ADDR_W-1:0]          rdAddrA,
  input  logic [ADDR_W-1:0]          rdAddrB,
  output logic                       fwdHitA,
  output logic [DATA_W-1:0]          fwdDataA,
  output logic                       fwdHitB,
  output logic [DATA_W-1:0]          fwdDataB,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] XZR = {ADDR_W{1'b1}};

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;

  logic              not_full;
  logic              accept;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              push;
  logic              pop;
  logic [PTR_W-1:0]  idx;

  // Readiness depends only on the occupancy at cycle start, so a full
  // queue stays not-ready even when it drains on the same edge. The ALU
  // yields to any memory request; there is no path from alu_valid to
  // mem_ready.
  assign not_full  = (count_q != CNT_W'(DEPTH));
  assign mem_ready = not_full;
  assign alu_ready = not_full & ~mem_valid;

  // At most one producer is accepted per cycle; when memory is valid the
  // ALU is never ready, so the mux select can be mem_valid alone.
  assign accept  = (mem_valid & mem_ready) | (alu_valid & alu_ready);
  assign in_addr = mem_valid ? mem_addr : alu_addr;
  assign in_data = mem_valid ? mem_data : alu_data;

  // XZR writes complete their handshake but never occupy an entry.
  assign push = accept & (in_addr != XZR);
  assign pop  = (count_q != '0) & ~hold;

  // The head drives the register-file port directly and pops on the same
  // edge it is captured; the port idles at zero when nothing is written.
  assign write  = pop;
  assign wrAddr = pop ? addr_q[rd_ptr] : '0;
  assign wrData = pop ? data_q[rd_ptr] : '0;
  assign count  = count_q;

  // Pointers and occupancy. DEPTH is a power of two so the pointers wrap
  // naturally; count only moves by one and is bounded by the ready logic
  // (no push when full) and the drain logic (no pop when empty).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage needs no reset: an entry is only ever read while the
  // occupancy says it holds valid data.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= in_addr;
      data_q[wr_ptr] <= in_data;
    end
  end

  // Forwarding walks the occupied entries from oldest to youngest so the
  // last match seen is the youngest. The head being written this cycle is
  // still in the queue and therefore still forwards; an entry being
  // enqueued this cycle is not yet occupied and does not.
  always_comb begin
    fwdHitA  = 1'b0;
    fwdDataA = '0;
    fwdHitB  = 1'b0;
    fwdDataB = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < count_q) begin
        if ((addr_q[idx] == rdAddrA) && (rdAddrA != XZR)) begin
          fwdHitA  = 1'b1;
          fwdDataA = data_q[idx];
        end
        if ((addr_q[idx] == rdAddrB) && (rdAddrB != XZR)) begin
          fwdHitB  = 1'b1;
          fwdDataB = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb_regfile_writeback_queue
//
// Directed testbench for regfile_writeback_queue. Each task drives one
// scenario and compares outputs against hand-computed values. Inputs are
// driven 1 time unit after the rising edge; outputs are sampled before the
// next rising edge.
module tb_regfile_writeback_queue;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              reset;
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              hold;
  logic              write;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;
  logic [ADDR_W-1:0] rdAddrA;
  logic [ADDR_W-1:0] rdAddrB;
  logic              fwdHitA;
  logic [DATA_W-1:0] fwdDataA;
  logic              fwdHitB;
  logic [DATA_W-1:0] fwdDataB;
  logic [2:0]        count;

  int compared = 0;
  int failed   = 0;

  regfile_writeback_queue #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .alu_valid(alu_valid),
    .alu_ready(alu_ready),
    .alu_addr (alu_addr),
    .alu_data (alu_data),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .hold     (hold),
    .write    (write),
    .wrAddr   (wrAddr),
    .wrData   (wrData),
    .rdAddrA  (rdAddrA),
    .rdAddrB  (rdAddrB),
    .fwdHitA  (fwdHitA),
    .fwdDataA (fwdDataA),
    .fwdHitB  (fwdHitB),
    .fwdDataB (fwdDataB),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    alu_valid = 1'b0;
    alu_addr  = '0;
    alu_data  = '0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_data  = '0;
    hold      = 1'b0;
    rdAddrA   = 5'd0;
    rdAddrB   = 5'd0;
    tick();
    tick();
    compared++;
    if (write !== 1'b0) begin failed++; $display("[TB] FAIL reset_write: got %b expected 0", write); end
    reset = 1'b1;
    tick();
    compared++;
    if (count !== 3'd0) begin failed++; $display("[TB] FAIL idle_count: got %0d expected 0", count); end
    compared++;
    if (write !== 1'b0) begin failed++; $display("[TB] FAIL idle_write: got %b expected 0", write); end
    compared++;
    if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
      failed++; $display("[TB] FAIL idle_ready: got alu=%b mem=%b expected 1 1", alu_ready, mem_ready);
    end
    compared++;
    if (fwdHitA !== 1'b0 || fwdDataA !== 64'd0) begin
      failed++; $display("[TB] FAIL idle_fwd: got hit=%b data=%h expected 0 0", fwdHitA, fwdDataA);
    end
    compared++;
    if (wrAddr !== 5'd0 || wrData !== 64'd0) begin
      failed++; $display("[TB] FAIL idle_port: got addr=%0d data=%h expected 0 0", wrAddr, wrData);
    end
  endtask

  task automatic test_single_write();
    alu_valid = 1'b1;
    alu_addr  = 5'd5;
    alu_data  = 64'hDEAD_BEEF_0000_0005;
    #1;
    compared++;
    if (alu_ready !== 1'b1) begin failed++; $display("[TB] FAIL single_ready: got %b expected 1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    #1;
    compared++;
    if (write !== 1'b1 || wrAddr !== 5'd5 || wrData !== 64'hDEAD_BEEF_0000_0005) begin
      failed++; $display("[TB] FAIL single_write: got w=%b addr=%0d data=%h expected 1 5 deadbeef00000005", write, wrAddr, wrData);
    end
    compared++;
    if (count !== 3'd1) begin failed++; $display("[TB] FAIL single_count1: got %0d expected 1", count); end
    tick();
    compared++;
    if (count !== 3'd0 || write !== 1'b0) begin
      failed++; $display("[TB] FAIL single_drained: got count=%0d w=%b expected 0 0", count, write);
    end
  endtask

  // Builds a held queue (3,1) (7,2) (3,3) (9,99), checks forwarding and
  // the full condition, then releases and checks the in-order drain with
  // a stalled memory request entering behind it.
  task automatic test_forwarding_and_full();
    hold      = 1'b1;
    alu_valid = 1'b1;
    alu_addr  = 5'd3;  alu_data = 64'd1; tick();
    alu_addr  = 5'd7;  alu_data = 64'd2; tick();
    alu_addr  = 5'd3;  alu_data = 64'd3; tick();
    alu_valid = 1'b0;
    rdAddrA   = 5'd3;
    rdAddrB   = 5'd7;
    #1;
    compared++;
    if (count !== 3'd3) begin failed++; $display("[TB] FAIL held_count3: got %0d expected 3", count); end
    compared++;
    if (write !== 1'b0 || wrAddr !== 5'd0 || wrData !== 64'd0) begin
      failed++; $display("[TB] FAIL held_port_idle: got w=%b addr=%0d data=%h expected 0 0 0", write, wrAddr, wrData);
    end
    compared++;
    if (fwdHitA !== 1'b1 || fwdDataA !== 64'd3) begin
      failed++; $display("[TB] FAIL fwd_youngest_a: got hit=%b data=%h expected 1 3", fwdHitA, fwdDataA);
    end
    compared++;
    if (fwdHitB !== 1'b1 || fwdDataB !== 64'd2) begin
      failed++; $display("[TB] FAIL fwd_b: got hit=%b data=%h expected 1 2", fwdHitB, fwdDataB);
    end
    rdAddrA = 5'd31;
    #1;
    compared++;
    if (fwdHitA !== 1'b0 || fwdDataA !== 64'd0) begin
      failed++; $display("[TB] FAIL fwd_xzr: got hit=%b data=%h expected 0 0", fwdHitA, fwdDataA);
    end
    // An entry being enqueued this cycle must not forward yet.
    alu_valid = 1'b1;
    alu_addr  = 5'd9;
    alu_data  = 64'd99;
    rdAddrB   = 5'd9;
    #1;
    compared++;
    if (fwdHitB !== 1'b0) begin failed++; $display("[TB] FAIL fwd_incoming: got hit=%b expected 0", fwdHitB); end
    tick();
    alu_valid = 1'b0;
    #1;
    compared++;
    if (fwdHitB !== 1'b1 || fwdDataB !== 64'd99) begin
      failed++; $display("[TB] FAIL fwd_new_entry: got hit=%b data=%h expected 1 63", fwdHitB, fwdDataB);
    end
    compared++;
    if (count !== 3'd4 || alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
      failed++; $display("[TB] FAIL full_state: got count=%0d alu=%b mem=%b expected 4 0 0", count, alu_ready, mem_ready);
    end
    // Fifth request stalls while held.
    mem_valid = 1'b1;
    mem_addr  = 5'd12;
    mem_data  = 64'd12;
    tick();
    compared++;
    if (count !== 3'd4) begin failed++; $display("[TB] FAIL full_stall: got count=%0d expected 4", count); end
    // Release: the first drain cycle still refuses the stalled request.
    hold = 1'b0;
    #1;
    compared++;
    if (mem_ready !== 1'b0 || write !== 1'b1 || wrAddr !== 5'd3 || wrData !== 64'd1) begin
      failed++; $display("[TB] FAIL drain0: got rdy=%b w=%b addr=%0d data=%h expected 0 1 3 1", mem_ready, write, wrAddr, wrData);
    end
    tick();
    compared++;
    if (count !== 3'd3 || mem_ready !== 1'b1 || wrAddr !== 5'd7 || wrData !== 64'd2) begin
      failed++; $display("[TB] FAIL drain1: got count=%0d rdy=%b addr=%0d data=%h expected 3 1 7 2", count, mem_ready, wrAddr, wrData);
    end
    tick();
    mem_valid = 1'b0;
    #1;
    compared++;
    if (count !== 3'd3 || write !== 1'b1 || wrAddr !== 5'd3 || wrData !== 64'd3) begin
      failed++; $display("[TB] FAIL drain2: got count=%0d w=%b addr=%0d data=%h expected 3 1 3 3", count, write, wrAddr, wrData);
    end
    tick();
    compared++;
    if (count !== 3'd2 || wrAddr !== 5'd9 || wrData !== 64'd99) begin
      failed++; $display("[TB] FAIL drain3: got count=%0d addr=%0d data=%h expected 2 9 63", count, wrAddr, wrData);
    end
    tick();
    compared++;
    if (count !== 3'd1 || wrAddr !== 5'd12 || wrData !== 64'd12) begin
      failed++; $display("[TB] FAIL drain4: got count=%0d addr=%0d data=%h expected 1 12 c", count, wrAddr, wrData);
    end
    tick();
    compared++;
    if (count !== 3'd0 || write !== 1'b0) begin
      failed++; $display("[TB] FAIL drain_empty: got count=%0d w=%b expected 0 0", count, write);
    end
  endtask

  task automatic test_priority();
    mem_valid = 1'b1; mem_addr = 5'd9;  mem_data = 64'h90;
    alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 64'hA0;
    #1;
    compared++;
    if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
      failed++; $display("[TB] FAIL prio_ready: got mem=%b alu=%b expected 1 0", mem_ready, alu_ready);
    end
    tick();
    mem_valid = 1'b0;
    #1;
    compared++;
    if (alu_ready !== 1'b1 || write !== 1'b1 || wrAddr !== 5'd9 || wrData !== 64'h90) begin
      failed++; $display("[TB] FAIL prio_first: got rdy=%b w=%b addr=%0d data=%h expected 1 1 9 90", alu_ready, write, wrAddr, wrData);
    end
    tick();
    alu_valid = 1'b0;
    #1;
    compared++;
    if (count !== 3'd1 || wrAddr !== 5'd10 || wrData !== 64'hA0) begin
      failed++; $display("[TB] FAIL prio_second: got count=%0d addr=%0d data=%h expected 1 10 a0", count, wrAddr, wrData);
    end
    tick();
    compared++;
    if (count !== 3'd0) begin failed++; $display("[TB] FAIL prio_empty: got %0d expected 0", count); end
  endtask

  task automatic test_xzr_drop();
    alu_valid = 1'b1;
    alu_addr  = 5'd31;
    alu_data  = 64'h1234;
    #1;
    compared++;
    if (alu_ready !== 1'b1) begin failed++; $display("[TB] FAIL xzr_ready: got %b expected 1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    #1;
    compared++;
    if (count !== 3'd0 || write !== 1'b0) begin
      failed++; $display("[TB] FAIL xzr_dropped: got count=%0d w=%b expected 0 0", count, write);
    end
    tick();
    compared++;
    if (write !== 1'b0) begin failed++; $display("[TB] FAIL xzr_no_write: got %b expected 0", write); end
  endtask

  task automatic test_async_reset();
    hold      = 1'b1;
    alu_valid = 1'b1;
    alu_addr  = 5'd4; alu_data = 64'd44; tick();
    alu_addr  = 5'd6; alu_data = 64'd66; tick();
    alu_valid = 1'b0;
    hold      = 1'b0;
    rdAddrA   = 5'd4;
    #1;
    compared++;
    if (count !== 3'd2 || write !== 1'b1 || fwdHitA !== 1'b1) begin
      failed++; $display("[TB] FAIL pre_reset: got count=%0d w=%b hit=%b expected 2 1 1", count, write, fwdHitA);
    end
    // Mid-cycle, well away from any clock edge.
    reset = 1'b0;
    #1;
    compared++;
    if (count !== 3'd0 || write !== 1'b0 || wrAddr !== 5'd0 || wrData !== 64'd0 || fwdHitA !== 1'b0) begin
      failed++; $display("[TB] FAIL async_reset: got count=%0d w=%b addr=%0d data=%h hit=%b expected 0 0 0 0 0",
                         count, write, wrAddr, wrData, fwdHitA);
    end
    tick();
    reset = 1'b1;
    tick();
    compared++;
    if (count !== 3'd0 || write !== 1'b0) begin
      failed++; $display("[TB] FAIL post_reset: got count=%0d w=%b expected 0 0", count, write);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_forwarding_and_full();
    test_priority();
    test_xzr_drop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
